csr_regfile: RTL and testbench

//  Parametrised byte-wide control/status register file for the mixer/SPDIF path; successor of the fixed 2-channel csr.

---
 rtl/csr_regfile.sv | 138 +++++++++++++
 tb/tb_csr_regfile.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/csr_regfile.sv
// Byte-wide CSR file for the mixer/SPDIF path: per-channel volumes with atomic commit,
// SPDIF user/channel-status snapshots, sticky W1C change status and a masked interrupt.
module csr_regfile #(
    parameter int          NUM_CH    = 2,
    parameter int          VOL_W     = 32,
    parameter logic [31:0] VOL_RESET = 32'h0100_0000,
    parameter int          SPD_W     = 384
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [11:0]             addr_i,
    input  logic                    ack_i,
    input  logic                    wr_i,
    input  logic [7:0]              data_i,
    output logic [7:0]              data_o,
    input  logic [7:0]              rate_i,
    input  logic [SPD_W-1:0]        udata_i,
    input  logic [SPD_W-1:0]        cdata_i,
    output logic [NUM_CH*VOL_W-1:0] vol_o,
    output logic                    irq_o
);

    localparam int VB  = VOL_W / 8;
    localparam int SB  = SPD_W / 8;
    localparam int TOP = VB - 1;

    logic [VOL_W-1:0] staging_q [NUM_CH];
    logic [VOL_W-1:0] vol_q     [NUM_CH];
    logic [SPD_W-1:0] udata_sh, cdata_sh, udata_q, cdata_q;
    logic [7:0]       rate_q, mask_q, rd_data;
    logic [2:0]       status_q, status_set, status_clr, status_next;
    logic [VOL_W-1:0] commit_word;

    logic       rd_en, wr_en, vol_hit, udata_hit, cdata_hit;
    logic [5:0] vol_ch;
    logic [1:0] vol_byte;
    logic [9:0] spd_byte;

    assign rd_en     = ack_i & ~wr_i;
    assign wr_en     = ack_i & wr_i;
    assign vol_ch    = addr_i[7:2];
    assign vol_byte  = addr_i[1:0];
    assign spd_byte  = addr_i[9:0];
    assign vol_hit   = (addr_i[11:8] == 4'h0) && (32'(vol_ch) < NUM_CH) && (32'(vol_byte) < VB);
    assign udata_hit = (addr_i[11:10] == 2'b10) && (32'(spd_byte) < SB);
    assign cdata_hit = (addr_i[11:10] == 2'b11) && (32'(spd_byte) < SB);

    always_comb begin
        rd_data = 8'h00;
        for (int ch = 0; ch < NUM_CH; ch++)
            for (int by = 0; by < VB; by++)
                if (vol_hit && vol_ch == 6'(ch) && vol_byte == 2'(by))
                    rd_data = vol_q[ch][8*by +: 8];
        case (addr_i)
            12'h100: rd_data = rate_i;
            12'h101: rd_data = {5'b0, status_q};
            12'h102: rd_data = mask_q;
            default: ;
        endcase
        // Byte 0 of each snapshot window returns live data; the rest come from the shadow.
        if (udata_hit) begin
            if (spd_byte == 10'd0)
                rd_data = udata_i[7:0];
            for (int k = 1; k < SB; k++)
                if (spd_byte == 10'(k))
                    rd_data = udata_sh[8*k +: 8];
        end
        if (cdata_hit) begin
            if (spd_byte == 10'd0)
                rd_data = cdata_i[7:0];
            for (int k = 1; k < SB; k++)
                if (spd_byte == 10'(k))
                    rd_data = cdata_sh[8*k +: 8];
        end
    end

    // Committed word is the staging value with the incoming top byte merged in.
    always_comb begin
        commit_word = '0;
        for (int ch = 0; ch < NUM_CH; ch++)
            if (vol_ch == 6'(ch))
                commit_word = staging_q[ch];
        commit_word[8*TOP +: 8] = data_i;
    end

    always_comb begin
        status_set  = {cdata_i != cdata_q, udata_i != udata_q, rate_i != rate_q};
        status_clr  = (wr_en && addr_i == 12'h101) ? data_i[2:0] : 3'b000;
        status_next = (status_q & ~status_clr) | status_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_o   <= 8'h00;
            status_q <= 3'b000;
            mask_q   <= 8'h00;
            irq_o    <= 1'b0;
            udata_sh <= '0;
            cdata_sh <= '0;
            rate_q   <= rate_i;
            udata_q  <= udata_i;
            cdata_q  <= cdata_i;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                staging_q[ch] <= VOL_RESET[VOL_W-1:0];
                vol_q[ch]     <= VOL_RESET[VOL_W-1:0];
            end
        end else begin
            rate_q   <= rate_i;
            udata_q  <= udata_i;
            cdata_q  <= cdata_i;
            status_q <= status_next;
            irq_o    <= |({5'b0, status_next} & mask_q);
            if (wr_en && addr_i == 12'h102)
                mask_q <= data_i;
            if (rd_en) begin
                data_o <= rd_data;
                if (addr_i == 12'h800)
                    udata_sh <= udata_i;
                if (addr_i == 12'hC00)
                    cdata_sh <= cdata_i;
            end
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (wr_en && vol_hit && vol_ch == 6'(ch)) begin
                    for (int by = 0; by < VB; by++)
                        if (vol_byte == 2'(by))
                            staging_q[ch][8*by +: 8] <= data_i;
                    if (vol_byte == 2'(TOP))
                        vol_q[ch] <= commit_word;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_vol
        assign vol_o[g*VOL_W +: VOL_W] = vol_q[g];
    end

endmodule

// File: tb/tb_csr_regfile.sv
// Directed self-checking bench for csr_regfile with default parameters (2 ch, 32-bit volumes, 384-bit SPDIF).
module tb_csr_regfile;

    logic         clk = 1'b0;
    logic         rst;
    logic [11:0]  addr_i;
    logic         ack_i, wr_i;
    logic [7:0]   data_i, data_o, rate_i;
    logic [383:0] udata_i, cdata_i;
    logic [63:0]  vol_o;
    logic         irq_o;

    int checks   = 0;
    int failures = 0;

    csr_regfile dut (
        .clk(clk), .rst(rst), .addr_i(addr_i), .ack_i(ack_i), .wr_i(wr_i),
        .data_i(data_i), .data_o(data_o), .rate_i(rate_i), .udata_i(udata_i),
        .cdata_i(cdata_i), .vol_o(vol_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One bus access, driven at a falling edge; returns just after the following falling edge.
    task automatic applyStimulus(input logic [11:0] a, input logic w, input logic [7:0] d);
        @(negedge clk);
        addr_i = a; wr_i = w; data_i = d; ack_i = 1'b1;
        @(negedge clk);
        ack_i = 1'b0; wr_i = 1'b0;
    endtask

    task automatic readCheck(input string tag, input logic [11:0] a, input logic [7:0] expected);
        applyStimulus(a, 1'b0, 8'h00);
        checkOutput(tag, {56'b0, data_o}, {56'b0, expected});
    endtask

    initial begin
        rst = 1'b1; addr_i = '0; ack_i = 1'b0; wr_i = 1'b0; data_i = '0;
        rate_i = 8'hab; udata_i = '0; cdata_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_vol",  vol_o, 64'h01000000_01000000);
        checkOutput("rst_data", {56'b0, data_o}, 64'h0);
        checkOutput("rst_irq",  {63'b0, irq_o}, 64'h0);
        readCheck("rst_status", 12'h101, 8'h00);

        $display("[TB] volume staging and commit");
        applyStimulus(12'h004, 1'b1, 8'hEF);
        applyStimulus(12'h005, 1'b1, 8'hCD);
        applyStimulus(12'h006, 1'b1, 8'hAB);
        checkOutput("vol_low_bytes_no_commit", vol_o, 64'h01000000_01000000);
        applyStimulus(12'h007, 1'b1, 8'h89);
        checkOutput("vol_commit_ch1", vol_o, 64'h89ABCDEF_01000000);
        readCheck("vol_rd_007", 12'h007, 8'h89);
        readCheck("vol_rd_004", 12'h004, 8'hEF);
        applyStimulus(12'h000, 1'b1, 8'h55);
        readCheck("vol_rd_committed_not_staging", 12'h000, 8'h00);
        applyStimulus(12'h003, 1'b1, 8'h77);
        checkOutput("vol_commit_ch0", vol_o, 64'h89ABCDEF_77000055);

        $display("[TB] snapshots");
        udata_i[15:0] = 16'h1234;
        readCheck("udata_live_800", 12'h800, 8'h34);
        udata_i[15:0] = 16'h5678;
        readCheck("udata_shadow_801", 12'h801, 8'h12);
        cdata_i[15:0] = 16'hA55A;
        readCheck("cdata_live_c00", 12'hC00, 8'h5A);
        cdata_i[15:0] = 16'hFFFF;
        readCheck("cdata_shadow_c01", 12'hC01, 8'hA5);
        readCheck("udata_shadow_independent", 12'h801, 8'h12);
        readCheck("status_data_changes", 12'h101, 8'h06);
        applyStimulus(12'h101, 1'b1, 8'h07);
        readCheck("status_w1c_all", 12'h101, 8'h00);

        $display("[TB] rate change and interrupt");
        applyStimulus(12'h102, 1'b1, 8'h01);
        readCheck("mask_rd", 12'h102, 8'h01);
        checkOutput("irq_idle", {63'b0, irq_o}, 64'h0);
        rate_i = 8'h44;
        @(negedge clk);
        checkOutput("irq_rate_set", {63'b0, irq_o}, 64'h1);
        readCheck("status_rate", 12'h101, 8'h01);
        readCheck("rate_live", 12'h100, 8'h44);
        applyStimulus(12'h101, 1'b1, 8'h01);
        checkOutput("irq_cleared", {63'b0, irq_o}, 64'h0);
        readCheck("status_cleared", 12'h101, 8'h00);

        $display("[TB] set wins over clear");
        @(negedge clk);
        addr_i = 12'h101; wr_i = 1'b1; data_i = 8'h01; ack_i = 1'b1; rate_i = 8'h99;
        @(negedge clk);
        ack_i = 1'b0; wr_i = 1'b0;
        checkOutput("irq_set_wins", {63'b0, irq_o}, 64'h1);
        readCheck("status_set_wins", 12'h101, 8'h01);
        applyStimulus(12'h101, 1'b1, 8'h01);
        readCheck("status_cleared_again", 12'h101, 8'h00);

        $display("[TB] unmapped addresses");
        readCheck("unmapped_0ff", 12'h0FF, 8'h00);
        readCheck("unmapped_900", 12'h900, 8'h00);
        readCheck("unmapped_830", 12'h830, 8'h00);
        readCheck("mask_before_unmapped_wr", 12'h102, 8'h01);
        applyStimulus(12'h0FF, 1'b1, 8'hFF);
        checkOutput("data_o_held_after_write", {56'b0, data_o}, 64'h01);
        readCheck("unmapped_008", 12'h008, 8'h00);
        applyStimulus(12'h900, 1'b1, 8'hFF);
        applyStimulus(12'h008, 1'b1, 8'hFF);
        applyStimulus(12'h00B, 1'b1, 8'hFF);
        applyStimulus(12'h103, 1'b1, 8'hFF);
        checkOutput("unmapped_wr_vol", vol_o, 64'h89ABCDEF_77000055);
        readCheck("unmapped_wr_status", 12'h101, 8'h00);
        readCheck("unmapped_wr_mask", 12'h102, 8'h01);
        checkOutput("unmapped_wr_irq", {63'b0, irq_o}, 64'h0);

        $display("[TB] reset mid-sequence");
        applyStimulus(12'h000, 1'b1, 8'h11);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_vol", vol_o, 64'h01000000_01000000);
        readCheck("midrst_mask", 12'h102, 8'h00);
        applyStimulus(12'h003, 1'b1, 8'h22);
        checkOutput("midrst_staging_discarded", vol_o, 64'h01000000_22000000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
